// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: 4x4 keypad row scanner with a column synchroniser.
// Debounces both press and release, freezes the row rotation while a key is
// in play, and emits one key_valid pulse with a hex key_code per accepted press.
//
// Optional feature macro: KEY_REPEAT_EN. When it is defined, a held single key
// re-pulses key_valid after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad row drive, active-low, one row low at a time
//   col[3:0]   keypad columns, pulled up, low = pressed (asynchronous)
//   key_code   hex code of the last accepted key, held until the next one
//   key_valid  single-cycle pulse per accepted press
//   key_held   high while a debounced key is down
//   scan_stop  high whenever the row rotation is frozen
module keypad_scan_fsm #(
  parameter int unsigned SCAN_DIV        = 3000,
  parameter int unsigned DEBOUNCE_CYCLES = 60000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned REPEAT_DELAY    = 1500000,
  parameter int unsigned REPEAT_PERIOD   = 300000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       scan_stop
);

  localparam int unsigned SyncN  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDbPress, StHeld, StDbRelease} state_e;

  state_e          state_q, state_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      col_lat_q, col_lat_d;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            pend_q, pend_d;
  logic            press_fire, rep_fire;
  logic [3:0]      col_s;
  logic [4:0]      dec;
  logic            single_key;
  logic [3:0]      dec_code;

  // Column synchroniser; idles at "no key" so reset never looks like a press.
  logic [3:0] sync_q [SyncN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SyncN; i++) sync_q[i] <= 4'hF;
    end else begin
      sync_q[0] <= col;
      for (int i = 1; i < SyncN; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign col_s = sync_q[SyncN-1];

  // Returns {single_key, code}; single_key is low for multi-key (ghost) patterns.
  function automatic logic [4:0] decode(input logic [1:0] r, input logic [3:0] c);
    logic [1:0] ci;
    logic       ok;
    logic [3:0] code;
    ok = 1'b1;
    ci = 2'd0;
    case (c)
      4'b1110: ci = 2'd0;
      4'b1101: ci = 2'd1;
      4'b1011: ci = 2'd2;
      4'b0111: ci = 2'd3;
      default: ok = 1'b0;
    endcase
    case ({r, ci})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return {ok, code};
  endfunction

  assign dec        = decode(row_idx_q, col_lat_q);
  assign single_key = dec[4];
  assign dec_code   = dec[3:0];

  // Saturating increment so a stalled count never wraps mid-debounce.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    col_lat_d  = col_lat_q;
    press_fire = 1'b0;
    unique case (state_q)
      StScan: begin
        // Sample only on the last dwell cycle so col_s reflects this row.
        if (cnt_q >= ScanLast) begin
          cnt_d = '0;
          if (col_s != 4'hF) begin
            state_d   = StDbPress;
            col_lat_d = col_s;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDbPress: begin
        if (col_s != col_lat_q) begin
          state_d   = StScan;
          row_idx_d = row_idx_q + 2'd1;
          cnt_d     = '0;
        end else if (cnt_q >= DebLast) begin
          state_d    = StHeld;
          cnt_d      = '0;
          press_fire = single_key;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeld: begin
        if (col_s == 4'hF) begin
          state_d = StDbRelease;
          cnt_d   = '0;
        end
      end
      StDbRelease: begin
        if (col_s != 4'hF) begin
          state_d = StHeld;
        end else if (cnt_q >= DebLast) begin
          state_d   = StScan;
          row_idx_d = row_idx_q + 2'd1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StScan;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;

  // Counts only in HELD, pauses through DB_RELEASE, clears everywhere else.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (state_q == StHeld) begin
      if (single_key) begin
        if (rep_cnt_q >= (rep_first_q ? RepDelayLast : RepPeriodLast)) begin
          rep_fire    = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end else if (state_q != StDbRelease) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire      = 1'b0;
`endif

  assign pend_d = press_fire | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StScan;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      col_lat_q   <= 4'hF;
      pend_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      col_lat_q   <= col_lat_d;
      pend_q      <= pend_d;
      // One-cycle pipeline so the pulse lands the cycle after HELD is entered.
      key_valid_q <= pend_q;
      if (pend_q) key_code_q <= dec_code;
    end
  end

  assign row       = ~(4'b0001 << row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == StHeld) || (state_q == StDbRelease);
  assign scan_stop = (state_q != StScan);

endmodule

// File: tb/tb_keypad_scan_fsm.sv
module tb_keypad_scan_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       scan_stop;

  // Keypad model: one key (or key combination) on key_row pulls key_cols low.
  logic       key_on = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [3:0] key_cols = 4'hF;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp_code;
  logic       prev_valid = 1'b0;
  logic       held_ok;
  int         lat;

  keypad_scan_fsm #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2),
    .REPEAT_DELAY    (40),
    .REPEAT_PERIOD   (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .scan_stop (scan_stop)
  );

  always #5 clk = ~clk;

  always_comb col = (key_on && (row == ~(4'b0001 << key_row))) ? key_cols : 4'hF;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return key_held;
      default: return scan_stop;
    endcase
  endfunction

  // Bounded wait at negedges for key_held (sel 0) or scan_stop (sel 1) to equal val.
  task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sig(sel) !== val) begin
      errors++;
      $display("FAIL %s: timed out after %0d cycles, got %b, expected %b",
               name, n, sig(sel), val);
    end
  endtask

  // Scoreboard monitor: every key_valid pulse pops one expected code.
  initial begin
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL pulse_width: key_valid high on consecutive cycles, got 1 expected 0");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got key_valid with code %h, expected no pulse",
                   key_code);
        end else begin
          exp_code = exp_q.pop_front();
          if (key_code !== exp_code) begin
            errors++;
            $display("FAIL pulse_code: got %h, expected %h", key_code, exp_code);
          end
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0] r;
    logic [3:0] c;
    logic [3:0] code;
  } key_vec_t;

  key_vec_t keys [6] = '{
    '{2'd3, 4'b0111, 4'hD},
    '{2'd0, 4'b1110, 4'h1},
    '{2'd2, 4'b1011, 4'h9},
    '{2'd3, 4'b1101, 4'h0},
    '{2'd0, 4'b0111, 4'hA},
    '{2'd3, 4'b1110, 4'hE}
  };

  logic [3:0] row_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check4("rst_row", row, 4'b1110);
    check4("rst_code", key_code, 4'h0);
    check4("rst_valid", {3'b0, key_valid}, 4'h0);
    check4("rst_held", {3'b0, key_held}, 4'h0);
    check4("rst_stop", {3'b0, scan_stop}, 4'h0);
    rst_n = 1'b1;

    // Idle rotation: 4 cycles per row
    for (int k = 0; k < 16; k++) begin
      check4("row_seq", row, row_pat[(k / 4) % 4]);
      @(negedge clk);
    end

    // Key 5 held for 100 cycles
    exp_q.push_back(4'h5);
    key_row = 2'd1; key_cols = 4'b1101; key_on = 1'b1;
    wait_sig(1, 1'b1, 40, "press5_detect");
    lat = 0;
    while (key_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_int("press5_latency", lat, 9);
    repeat (90) @(negedge clk);
    check4("press5_held", {3'b0, key_held}, 4'h1);
    check4("press5_row", row, 4'b1101);
    check4("press5_stop", {3'b0, scan_stop}, 4'h1);
    check4("press5_code", key_code, 4'h5);
    check_int("press5_pulses_left", exp_q.size(), 0);

    // Release bounce: 3 off, 2 on, then off for good
    held_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      key_on = (i >= 3 && i < 5);
      @(negedge clk);
      if (key_held !== 1'b1) held_ok = 1'b0;
    end
    check4("bounce_held", {3'b0, held_ok}, 4'h1);
    wait_sig(0, 1'b0, 30, "release5");
    check4("release5_row", row, 4'b1011);
    check4("release5_stop", {3'b0, scan_stop}, 4'h0);

    // Short press on row 1011 aborts the debounce
    key_row = 2'd2; key_cols = 4'b1110; key_on = 1'b1;
    wait_sig(1, 1'b1, 40, "short_detect");
    repeat (2) @(negedge clk);
    key_on = 1'b0;
    wait_sig(1, 1'b0, 30, "short_abort");
    check4("short_row", row, 4'b0111);
    check4("short_held", {3'b0, key_held}, 4'h0);

    // Two keys on row 1110: held but rejected
    key_row = 2'd0; key_cols = 4'b1100; key_on = 1'b1;
    wait_sig(0, 1'b1, 60, "multi_held");
    repeat (12) @(negedge clk);
    check4("multi_code_kept", key_code, 4'h5);
    check4("multi_still_held", {3'b0, key_held}, 4'h1);
    key_on = 1'b0;
    wait_sig(0, 1'b0, 40, "multi_release");

    // Asynchronous reset in DB_PRESS with the counter at 5
    key_row = 2'd2; key_cols = 4'b1110; key_on = 1'b1;
    wait_sig(1, 1'b1, 40, "rst_detect");
    repeat (5) @(negedge clk);
    check4("rst_pre_row", row, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check4("arst_row", row, 4'b1110);
    check4("arst_code", key_code, 4'h0);
    check4("arst_valid", {3'b0, key_valid}, 4'h0);
    check4("arst_held", {3'b0, key_held}, 4'h0);
    check4("arst_stop", {3'b0, scan_stop}, 4'h0);
    key_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check4("arst_restart_row0", row, 4'b1110);
    repeat (4) @(negedge clk);
    check4("arst_restart_row1", row, 4'b1101);

    // Key map sweep
    foreach (keys[i]) begin
      exp_q.push_back(keys[i].code);
      key_row = keys[i].r; key_cols = keys[i].c; key_on = 1'b1;
      wait_sig(0, 1'b1, 60, "map_press");
      key_on = 1'b0;
      wait_sig(0, 1'b0, 40, "map_release");
    end

    repeat (5) @(negedge clk);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
